// File: rtl/sample_counter_bank.sv
// Multi-channel sample address generator with per-voice loop/one-shot
// playback, retrigger, and choke groups for mutually exclusive voices.
module sample_counter_bank #(
    parameter int WIDTH    = 15,
    parameter int CHANNELS = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        en,
    input  logic [CHANNELS-1:0]         go,
    input  logic [CHANNELS-1:0]         loop,
    input  logic [CHANNELS-1:0]         choke,
    input  logic [CHANNELS*WIDTH-1:0]   max_count,
    output logic [CHANNELS*WIDTH-1:0]   count,
    output logic [CHANNELS-1:0]         active,
    output logic [CHANNELS-1:0]         done
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    logic [CHANNELS-1:0] grp_go;

    assign grp_go = go & choke;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [CHANNELS-1:0] SELF = CHANNELS'(1) << i;

        state_t           st, st_n;
        logic [WIDTH-1:0] cnt, cnt_n;
        logic [WIDTH-1:0] len, len_n;
        logic             lp, lp_n;
        logic             dn, dn_n;
        logic             choked;

        // A group member triggering silences every other member not itself retriggered.
        assign choked = choke[i] & ~go[i] & (|(grp_go & ~SELF));

        always_comb begin
            st_n  = st;
            cnt_n = cnt;
            len_n = len;
            lp_n  = lp;
            dn_n  = 1'b0;
            if (go[i]) begin
                st_n  = PLAY;
                cnt_n = '0;
                len_n = max_count[i*WIDTH +: WIDTH];
                lp_n  = loop[i];
            end else if (choked) begin
                st_n  = IDLE;
                cnt_n = '0;
            end else if (st == PLAY && en) begin
                if (cnt >= len) begin
                    dn_n  = 1'b1;
                    cnt_n = '0;
                    if (!lp) begin
                        st_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + WIDTH'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                st  <= IDLE;
                cnt <= '0;
                len <= '0;
                lp  <= 1'b0;
                dn  <= 1'b0;
            end else begin
                st  <= st_n;
                cnt <= cnt_n;
                len <= len_n;
                lp  <= lp_n;
                dn  <= dn_n;
            end
        end

        assign count[i*WIDTH +: WIDTH] = cnt;
        assign active[i]               = (st == PLAY);
        assign done[i]                 = dn;
    end

endmodule

// File: doc/sample_counter_bank.md
# sample_counter_bank

Multi-channel sample address generator for the drum sequencer's playback path. Each channel steps a sample-memory address from 0 to a per-channel length on a shared sample-rate tick, with retrigger, one-shot or loop mode, and a choke group for mutually exclusive voices such as open and closed hi-hat. It sits between the sequencer's trigger outputs and the sample ROM address muxes. One instance serves every drum voice.

## Interface
- WIDTH, 15: address width per channel.
- CHANNELS, 4: number of independent voices.
- clk  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- en  in  1  sample-rate tick, one clk wide, shared by all channels.
- go  in  CHANNELS  per-channel trigger pulse.
- loop  in  CHANNELS  per-channel mode: 1 = loop, 0 = one-shot. Sampled at trigger.
- choke  in  CHANNELS  choke-group membership, one bit per channel.
- max_count  in  CHANNELS*WIDTH  per-channel last address. Channel i occupies bits [i*WIDTH +: WIDTH]. Sampled at trigger.
- count  out  CHANNELS*WIDTH  per-channel current address, packed the same way as max_count.
- active  out  CHANNELS  channel is in PLAY.
- done  out  CHANNELS  one-cycle pulse when a channel passes its last address.

## Operation
- Each channel runs an independent two-state FSM with states IDLE and PLAY. Each channel holds these registers: count, len (latched max_count), lp (latched loop).
- Reset (resetn=0, asynchronous): every channel goes to IDLE. count=0, active=0, done=0, len=0, lp=0.
- Priority per channel per edge, highest first:
  1. go[i]=1: trigger.
  2. Choke from another channel.
  3. End-of-sample.
  4. Increment.
  5. Hold.
- Trigger (go[i]=1, any state): go to PLAY, count=0, len=max_count slice, lp=loop[i]. done[i]=0. A retrigger during PLAY restarts the channel from 0.
- Choke: if go[j]=1 with choke[j]=1 and choke[i]=1 for some j≠i, and go[i]=0, channel i goes to IDLE with count=0. done[i] is not pulsed. Simultaneous go on two members of the group starts both and chokes neither.
- Increment: in PLAY with en=1 and count<len, count=count+1.
- End-of-sample: in PLAY with en=1 and count>=len, done[i]=1 for the next cycle.
  - lp=1: count=0 and the channel stays in PLAY.
  - lp=0: count=0 and the channel goes to IDLE.
- Hold: in PLAY with en=0, count is unchanged. In IDLE, count stays 0 regardless of en.
- len=0: each en tick in PLAY is an end-of-sample. A one-shot channel therefore ends on its first tick.
- Changes to max_count or loop while a channel is in PLAY have no effect until the next trigger.
- Arithmetic is unsigned WIDTH-bit. count never exceeds len, so no wrap-around occurs.

## Timing
- All outputs are registered with no combinational path from inputs to outputs.
- Trigger latency: after the edge that samples go[i]=1, active[i]=1 and count=0.
- Each address 0..len is presented for exactly one en period. A one-shot channel pulses done after len+1 en ticks counted from the trigger.
- done[i] is high for exactly one clk cycle, in the cycle following the terminating en edge. On that same edge active[i] falls in one-shot mode.
- go[i] and en on the same edge: the trigger wins, count=0 and no increment occurs.
- resetn asserted mid-play: all outputs clear immediately without waiting for a clock edge. The first trigger after reset release behaves normally.

## Test plan
- Reset then one-shot: CHANNELS=4, WIDTH=15, max_count[0]=3, loop[0]=0, go[0] pulse, en every 4 clk.
  - count0 steps 0,1,2,3.
  - On the 4th tick, done[0] pulses 1 clk, active[0]=0 and count0=0.
  - Other channels stay at 0.
- Loop mode: max_count[1]=2, loop[1]=1.
  - count1 steps 0,1,2,0,1,2…
  - done[1] pulses on each wrap and active[1] stays 1.
- Retrigger and same-edge collision:
  - A go[0] at count0=2 restarts count0 at 0.
  - go[0] coincident with en gives count0=0, not 1.
- Choke: choke=4'b1100, channel 3 playing at count=5.
  - go[2] sends channel 3 to IDLE with count3=0 and no done[3], while channel 2 starts.
  - Simultaneous go[2] and go[3] starts both channels.
- Length latch and zero length:
  - Changing max_count[0] from 3 to 10 mid-play still ends at 3.
  - max_count=0 one-shot gives done on the first en.
- Async reset: drop resetn between clock edges mid-play. All outputs read 0 before the next clk edge.
